// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Bundles are sized for the widest configuration used (64-bit).
package addsub_pkg;

    localparam int MAX_W     = 64;
    localparam int MAX_TAG_W = 8;

    typedef struct packed {
        logic [MAX_W-1:0]     a;
        logic [MAX_W-1:0]     b;
        logic                 sub;
        logic                 cin;
        logic [MAX_TAG_W-1:0] tag;
    } addsub_req_t;

    typedef struct packed {
        logic [MAX_W-1:0]     sum;
        logic                 cout;
        logic                 ovf;
        logic                 zero;
        logic [MAX_TAG_W-1:0] tag;
    } addsub_rsp_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit ripple slice built from full_adder cells.
// Also exposes the carry into its MSB for overflow detection.
module addsub_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] sum_o,
    output logic          c_o,
    output logic          cmsb_o
);

    logic c [CW+1];

    assign c[0] = c_i;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (sum_o[i]),
            .c_o (c[i+1])
        );
    end

    assign c_o    = c[CW];
    assign cmsb_o = c[CW-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Ripple chains in addsub_chunk are built from these.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_addsub.sv
// Elastic STAGES-deep adder/subtractor: one chunk resolved per stage,
// carry handed forward in registers, per-stage advance for backpressure.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int CW = chunk_w(WIDTH, STAGES);
    localparam int L  = STAGES - 1;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic              m_q, m_d;

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic              accept;
    logic              go;
    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;

    logic [CW-1:0]     ch_a  [STAGES];
    logic [CW-1:0]     ch_b  [STAGES];
    logic [CW-1:0]     ch_s  [STAGES];
    logic              ch_ci [STAGES];
    logic              ch_co [STAGES];
    logic              ch_m  [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_chunk #(
            .CW (CW)
        ) u_chunk (
            .a_i    (ch_a[k]),
            .b_i    (ch_b[k]),
            .c_i    (ch_ci[k]),
            .sum_o  (ch_s[k]),
            .c_o    (ch_co[k]),
            .cmsb_o (ch_m[k])
        );
    end

    // Advance is resolved back-to-front so a full stage can move
    // in the same cycle as the one ahead of it drains.
    always_comb begin
        go = v_q[L] & out_ready_i;
        adv = '0;
        adv[L] = go;
        for (int k = L - 1; k >= 0; k--) begin
            go = v_q[k] & (~v_q[k+1] | go);
            adv[k] = go;
        end
        in_ready_o = ~v_q[0] | adv[0];
        accept = in_valid_i & in_ready_o & ~flush_i;
    end

    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        c_eff = sub_i ^ cin_i;
        ch_a[0]  = a_i[CW-1:0];
        ch_b[0]  = b_eff[CW-1:0];
        ch_ci[0] = c_eff;
        for (int k = 1; k < STAGES; k++) begin
            ch_a[k]  = a_q[k-1][k*CW +: CW];
            ch_b[k]  = b_q[k-1][k*CW +: CW];
            ch_ci[k] = c_q[k-1];
        end
    end

    always_comb begin
        ld = '0;
        ld[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = adv[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            tag_d[k] = tag_q[k];
        end
        c_d = c_q;
        m_d = m_q;
        if (ld[0]) begin
            a_d[0]   = a_i;
            b_d[0]   = b_eff;
            tag_d[0] = tag_i;
            s_d[0]   = '0;
            s_d[0][CW-1:0] = ch_s[0];
            c_d[0]   = ch_co[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                tag_d[k] = tag_q[k-1];
                s_d[k]   = s_q[k-1];
                s_d[k][k*CW +: CW] = ch_s[k];
                c_d[k]   = ch_co[k];
            end
        end
        if (ld[L]) begin
            m_d = ch_m[L];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (flush_i) begin
                v_d[k] = 1'b0;
            end else if (ld[k]) begin
                v_d[k] = 1'b1;
            end else if (adv[k]) begin
                v_d[k] = 1'b0;
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            c_q <= '0;
            m_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            m_q <= m_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign out_valid_o = v_q[L];
    assign sum_o       = s_q[L];
    assign cout_o      = c_q[L];
    assign ovf_o       = c_q[L] ^ m_q;
    assign zero_o      = v_q[L] & ~|s_q[L];
    assign tag_o       = tag_q[L];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: expected results are queued at
// acceptance and compared, with latency, when the DUT emits them.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          cin;
    logic [TW-1:0] tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int npop  = 0;
    bit lat_exact = 1'b0;

    addsub_rsp_t exp_q [$];
    int          acc_q [$];
    addsub_rsp_t e;
    int          t_acc;

    pipelined_addsub #(
        .WIDTH  (W),
        .STAGES (S),
        .TAG_W  (TW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .cin_i       (cin),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .zero_o      (zero),
        .tag_o       (tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic addsub_rsp_t model(
        input logic [W-1:0] ma, input logic [W-1:0] mb,
        input logic ms, input logic mc, input logic [TW-1:0] mt);
        addsub_rsp_t r;
        logic [W-1:0] be;
        logic [W:0]   full;
        be   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ms ^ mc};
        r      = '0;
        r.sum  = 64'(full[W-1:0]);
        r.cout = full[W];
        r.ovf  = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
        r.zero = (full[W-1:0] == '0);
        r.tag  = 8'(mt);
        return r;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst || flush) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e     = exp_q.pop_front();
                    t_acc = acc_q.pop_front();
                    chk("sum", 64'(sum), e.sum);
                    chk("cout", 64'(cout), 64'(e.cout));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                    chk("zero", 64'(zero), 64'(e.zero));
                    chk("tag", 64'(tag_out), 64'(e.tag));
                    if (lat_exact) chk("latency", 64'(cyc - t_acc), 64'(S));
                    npop++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub, cin, tag));
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb,
                        input logic ss, input logic sc,
                        input logic [TW-1:0] st);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        a = sa; b = sb; sub = ss; cin = sc; tag = st;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    initial begin
        int p0;
        int acc;
        int n;
        logic [W-1:0] ones;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0; tag = '0;
        ones = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        tick();

        lat_exact = 1'b1;
        send(W'(5), W'(3), 1'b0, 1'b0, TW'(7));
        drain();
        send(W'(3), W'(5), 1'b1, 1'b0, TW'(1));
        send(W'(1) << (W - 1), W'(1), 1'b1, 1'b0, TW'(2));
        send(ones, W'(0), 1'b0, 1'b1, TW'(3));
        send(ones >> 1, W'(1), 1'b0, 1'b0, TW'(4));
        send(ones, W'(1), 1'b0, 1'b0, TW'(5));
        drain();

        p0 = npop;
        for (int i = 0; i < 16; i++) begin
            send(rnd(), rnd(), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 TW'(i));
        end
        drain();
        chk("stream_cnt", 64'(npop - p0), 64'd16);

        lat_exact = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        p0 = npop;
        in_valid = 1'b1;
        a = rnd(); b = rnd(); sub = 1'b0; cin = 1'b0; tag = TW'(20);
        for (int i = 0; i < 10; i++) begin
            bit took;
            @(negedge clk);
            took = in_ready;
            tick();
            if (took) begin
                acc++;
                a = rnd(); b = rnd(); sub = ~sub; tag = TW'(21 + i);
            end
        end
        chk("bp_accepts", 64'(acc), 64'(S));
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        drain();
        chk("bp_popped", 64'(npop - p0), 64'(S));

        out_ready = 1'b0;
        n = (S < 3) ? S : 3;
        for (int i = 0; i < n; i++) begin
            send(rnd(), rnd(), 1'b0, 1'b0, TW'(40 + i));
        end
        flush = 1'b1;
        in_valid = 1'b1;
        a = rnd(); tag = TW'(63);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        p0 = npop;
        idle(S + 4);
        chk("flush_none", 64'(npop - p0), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        lat_exact = 1'b1;
        send(W'(100), W'(23), 1'b1, 1'b1, TW'(9));
        drain();
        chk("post_flush", 64'(npop - p0), 64'd1);

        send(rnd(), rnd(), 1'b0, 1'b0, TW'(11));
        send(rnd(), rnd(), 1'b0, 1'b0, TW'(12));
        in_valid = 1'b0;
        rst = 1'b1;
        p0 = npop;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_sum_tag", 64'({sum, tag_out}), 64'd0);
        tick();
        rst = 1'b0;
        idle(S + 2);
        chk("midrst_none", 64'(npop - p0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
